// File: rtl/ssc_pkg.sv
// Shared types and defaults for the square/ship code filter.
// Code pairs are always packed as {Ship, Square}: Square occupies the low
// SQ_W bits and Ship the SH_W bits above it.
package ssc_pkg;

    localparam int SQ_W_DEF = 12;
    localparam int SH_W_DEF = 8;

    // Bit position where the Ship field starts inside a packed code pair.
    localparam int SHIP_LSB_DEF = SQ_W_DEF;

    typedef enum logic [1:0] {
        ST_INIT   = 2'd0,
        ST_LOCKED = 2'd1,
        ST_SETTLE = 2'd2
    } state_t;

endpackage

// File: rtl/ssc_tick_gen.sv
// Sample-tick prescaler: counts 0..PRESC_DIV-1 and pulses tick on the last count.
// Latency: first tick is PRESC_DIV cycles after reset release; tick is combinational from the count.
// Backpressure: none, free-running.
// Ports: CLK (clock), nRESET (sync active-low reset), tick (one-cycle sample strobe).
module ssc_tick_gen
    import ssc_pkg::*;
#(
    parameter int PRESC_DIV = 1000
) (
    input  logic CLK,
    input  logic nRESET,
    output logic tick
);

    localparam int PW = (PRESC_DIV > 1) ? $clog2(PRESC_DIV) : 1;

    logic [PW-1:0] cnt_q;

    // With PRESC_DIV=1 the counter sits at 0 and tick is high every cycle.
    assign tick = (cnt_q == PW'(PRESC_DIV - 1));

    always_ff @(posedge CLK) begin
        if (!nRESET) begin
            cnt_q <= '0;
        end else if (tick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/ssc_code_filter.sv
// Debounces the raw {Ship,Square} code pair: a code is published after STABLE_N identical ticks.
// Latency: outputs register at the edge closing the locking tick (>= STABLE_N ticks after first match).
// Backpressure: none; chg_flag is sticky until chg_ack, unstable flags a settle timeout.
// Ports: CLK, nRESET (sync active-low), Square_in/Ship_in (raw codes), chg_ack (clears chg_flag),
//        Square_o/Ship_o (debounced code), code_valid, code_chg (pulse), chg_flag (sticky), unstable.
module ssc_code_filter
    import ssc_pkg::*;
#(
    parameter int PRESC_DIV = 1000,
    parameter int STABLE_N  = 4,
    parameter int TMO_N     = 32,
    parameter int SQ_W      = SQ_W_DEF,
    parameter int SH_W      = SH_W_DEF
) (
    input  logic            CLK,
    input  logic            nRESET,
    input  logic [SQ_W-1:0] Square_in,
    input  logic [SH_W-1:0] Ship_in,
    input  logic            chg_ack,
    output logic [SQ_W-1:0] Square_o,
    output logic [SH_W-1:0] Ship_o,
    output logic            code_valid,
    output logic            code_chg,
    output logic            chg_flag,
    output logic            unstable
);

    localparam int CW = SQ_W + SH_W;
    localparam int SW = $clog2(STABLE_N + 1);
    localparam int TW = $clog2(TMO_N + 1);

    logic          tick;
    logic [CW-1:0] sample;

    state_t        state_q, state_d;
    logic [CW-1:0] cand_q, cand_d;
    logic [SW-1:0] stab_q, stab_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [CW-1:0] pub_q, pub_d;
    logic          valid_q, valid_d;
    logic          chg_q, chg_d;
    logic          flag_q, flag_d;
    logic          unst_q, unst_d;
    logic          lock_now;

    ssc_tick_gen #(
        .PRESC_DIV (PRESC_DIV)
    ) u_tick (
        .CLK    (CLK),
        .nRESET (nRESET),
        .tick   (tick)
    );

    assign sample = {Ship_in, Square_in};

    // Stability tracker: runs on every tick regardless of FSM state, so the
    // FSM only needs to look at lock_now.
    always_comb begin
        cand_d = cand_q;
        stab_d = stab_q;
        if (sample == cand_q) begin
            if (stab_q != SW'(STABLE_N)) begin
                stab_d = stab_q + 1'b1;
            end
        end else begin
            cand_d = sample;
            stab_d = SW'(1);
        end
        lock_now = (stab_d == SW'(STABLE_N));
    end

    always_comb begin
        state_d = state_q;
        pub_d   = pub_q;
        valid_d = valid_q;
        chg_d   = 1'b0;
        unst_d  = unst_q;
        tmo_d   = tmo_q;
        if (tick) begin
            case (state_q)
                ST_INIT: begin
                    if (lock_now) begin
                        pub_d   = cand_d;
                        valid_d = 1'b1;
                        chg_d   = 1'b1;
                        state_d = ST_LOCKED;
                    end
                end
                ST_LOCKED: begin
                    if (sample != pub_q) begin
                        if (STABLE_N == 1) begin
                            // A single differing sample is already a lock.
                            pub_d = sample;
                            chg_d = 1'b1;
                        end else begin
                            state_d = ST_SETTLE;
                            tmo_d   = TW'(1);
                        end
                    end
                end
                ST_SETTLE: begin
                    if (lock_now) begin
                        // Re-locking onto the old code is a glitch: no publish.
                        if (cand_d != pub_q) begin
                            pub_d = cand_d;
                            chg_d = 1'b1;
                        end
                        unst_d  = 1'b0;
                        state_d = ST_LOCKED;
                    end else if (tmo_q == TW'(TMO_N)) begin
                        unst_d = 1'b1;
                    end else begin
                        tmo_d = tmo_q + 1'b1;
                    end
                end
                default: begin
                    state_d = ST_INIT;
                end
            endcase
        end
    end

    // The set source is the registered change pulse, so an ack landing in the
    // code_chg cycle loses against the set.
    always_comb begin
        flag_d = flag_q;
        if (chg_q) begin
            flag_d = 1'b1;
        end else if (chg_ack) begin
            flag_d = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRESET) begin
            state_q <= ST_INIT;
            cand_q  <= '0;
            stab_q  <= '0;
            tmo_q   <= '0;
            pub_q   <= '0;
            valid_q <= 1'b0;
            chg_q   <= 1'b0;
            flag_q  <= 1'b0;
            unst_q  <= 1'b0;
        end else begin
            if (tick) begin
                cand_q <= cand_d;
                stab_q <= stab_d;
            end
            state_q <= state_d;
            tmo_q   <= tmo_d;
            pub_q   <= pub_d;
            valid_q <= valid_d;
            chg_q   <= chg_d;
            flag_q  <= flag_d;
            unst_q  <= unst_d;
        end
    end

    assign Square_o   = pub_q[SQ_W-1:0];
    assign Ship_o     = pub_q[CW-1:SQ_W];
    assign code_valid = valid_q;
    assign code_chg   = chg_q;
    assign chg_flag   = flag_q;
    assign unstable   = unst_q;

endmodule

// File: tb/tb_ssc_code_filter.sv
module tb_ssc_code_filter;
    import ssc_pkg::*;

    localparam int PD = 4;
    localparam int SN = 3;
    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        nreset;
    logic [11:0] square_in;
    logic [7:0]  ship_in;
    logic        chg_ack;
    logic [11:0] square_o;
    logic [7:0]  ship_o;
    logic        code_valid, code_chg, chg_flag, unstable;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ssc_code_filter #(
        .PRESC_DIV (PD),
        .STABLE_N  (SN),
        .TMO_N     (TO),
        .SQ_W      (12),
        .SH_W      (8)
    ) dut (
        .CLK        (clk),
        .nRESET     (nreset),
        .Square_in  (square_in),
        .Ship_in    (ship_in),
        .chg_ack    (chg_ack),
        .Square_o   (square_o),
        .Ship_o     (ship_o),
        .code_valid (code_valid),
        .code_chg   (code_chg),
        .chg_flag   (chg_flag),
        .unstable   (unstable)
    );

    // ---------------- behavioural model ----------------
    logic [19:0] hist[$];
    int          m_cyc = 0, m_ticks = 0, m_entry = 0;
    bit          m_settling = 0, m_tick_edge = 0, m_init = 0;
    logic [11:0] e_sq = '0;
    logic [7:0]  e_sh = '0;
    bit          e_valid = 0, e_chg = 0, e_flag = 0, e_unst = 0;

    always @(posedge clk) begin
        logic [19:0] s;
        bit          stable;
        if (!nreset) begin
            hist.delete();
            m_cyc = 0; m_ticks = 0; m_entry = 0;
            m_settling = 0; m_tick_edge = 0; m_init = 1;
            e_sq = '0; e_sh = '0;
            e_valid = 0; e_chg = 0; e_flag = 0; e_unst = 0;
        end else begin
            e_flag = e_chg ? 1'b1 : (chg_ack ? 1'b0 : e_flag);
            e_chg = 0;
            m_tick_edge = ((m_cyc % PD) == PD - 1);
            m_cyc++;
            if (m_tick_edge) begin
                s = {ship_in, square_in};
                hist.push_back(s);
                if (hist.size() > SN) void'(hist.pop_front());
                stable = (hist.size() == SN);
                foreach (hist[i]) if (hist[i] != s) stable = 0;
                m_ticks++;
                if (!e_valid) begin
                    if (stable) begin
                        e_sq = s[11:0]; e_sh = s[19:12]; e_valid = 1; e_chg = 1;
                    end
                end else if (!m_settling) begin
                    if (s != {e_sh, e_sq}) begin
                        if (SN == 1) begin
                            e_sq = s[11:0]; e_sh = s[19:12]; e_chg = 1;
                        end else begin
                            m_settling = 1; m_entry = m_ticks;
                        end
                    end
                end else begin
                    if (stable) begin
                        if (s != {e_sh, e_sq}) begin
                            e_sq = s[11:0]; e_sh = s[19:12]; e_chg = 1;
                        end
                        m_settling = 0; e_unst = 0;
                    end else if (m_ticks - m_entry >= TO) begin
                        e_unst = 1;
                    end
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    bit seen_chg = 0;
    always @(negedge clk) begin
        if (m_init) begin
            total++;
            if ({square_o, ship_o, code_valid, code_chg, chg_flag, unstable} !==
                {e_sq, e_sh, e_valid, e_chg, e_flag, e_unst}) begin
                bad++;
                $display("FAIL model_cmp t=%0t actual sq=%h sh=%h v=%b c=%b f=%b u=%b required sq=%h sh=%h v=%b c=%b f=%b u=%b",
                         $time, square_o, ship_o, code_valid, code_chg, chg_flag, unstable,
                         e_sq, e_sh, e_valid, e_chg, e_flag, e_unst);
            end
            if (code_chg) seen_chg = 1;
        end
    end

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic next_tick();
        int n = 0;
        do begin
            step();
            n++;
        end while (!m_tick_edge && n < 20);
        if (!m_tick_edge) chk("tick_seen", 32'(m_tick_edge), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        int n;
        nreset = 0; square_in = 12'h0A5; ship_in = 8'h3C; chg_ack = 0;
        repeat (3) step();
        chk("rst_valid", 32'(code_valid), 0);
        chk("rst_sq", 32'(square_o), 0);
        chk("rst_flag", 32'(chg_flag), 0);
        chk("rst_unst", 32'(unstable), 0);

        // 1: first lock at cycle 12 after release
        nreset = 1;
        repeat (11) step();
        chk("t1_pre_valid", 32'(code_valid), 0);
        chk("t1_pre_chg", 32'(code_chg), 0);
        step();
        chk("t1_valid", 32'(code_valid), 1);
        chk("t1_chg", 32'(code_chg), 1);
        chk("t1_sq", 32'(square_o), 32'h0A5);
        chk("t1_sh", 32'(ship_o), 32'h3C);
        step();
        chk("t1_flag", 32'(chg_flag), 1);
        chk("t1_chg_pulse", 32'(code_chg), 0);
        chg_ack = 1; step(); chg_ack = 0;
        chk("ack_clear", 32'(chg_flag), 0);

        // 2: one-tick glitch returns to the old code
        next_tick(); square_in = 12'h0A4;
        next_tick(); square_in = 12'h0A5;
        seen_chg = 0;
        repeat (4) next_tick();
        chk("t2_no_chg", 32'(seen_chg), 0);
        chk("t2_sq", 32'(square_o), 32'h0A5);
        chk("t2_unst", 32'(unstable), 0);
        chk("t2_state", 32'(dut.state_q), 32'(ST_LOCKED));

        // 3: new square code, ack racing the set
        square_in = 12'h123;
        n = 0;
        do begin
            next_tick(); n++;
        end while (!code_chg && n < 6);
        chk("t3_ticks", 32'(n), 3);
        chk("t3_sq", 32'(square_o), 32'h123);
        chg_ack = 1;
        step();
        chk("t3_set_wins", 32'(chg_flag), 1);
        step();
        chg_ack = 0;
        chk("t3_ack_late", 32'(chg_flag), 0);

        // 4: ship toggling until timeout, then settle on 02
        ship_in = 8'h01;
        for (int k = 1; k <= 10; k++) begin
            next_tick();
            if (k == 8) chk("t4_unst_k8", 32'(unstable), 0);
            if (k == 9) begin
                chk("t4_unst_k9", 32'(unstable), 1);
                chk("t4_hold_sh", 32'(ship_o), 32'h3C);
            end
            if (k < 10) ship_in = (k % 2 == 1) ? 8'h02 : 8'h01;
        end
        next_tick();
        chk("t4_chg_early", 32'(code_chg), 0);
        next_tick();
        chk("t4_chg", 32'(code_chg), 1);
        chk("t4_sh", 32'(ship_o), 32'h02);
        chk("t4_unst_clr", 32'(unstable), 0);

        // 5: reset in SETTLE with two matching samples pending
        square_in = 12'h055;
        next_tick();
        next_tick();
        chk("t5_stab", 32'(dut.stab_q), 2);
        nreset = 0; step(); nreset = 1;
        chk("t5_valid", 32'(code_valid), 0);
        chk("t5_sq", 32'(square_o), 0);
        chk("t5_sh", 32'(ship_o), 0);
        chk("t5_flag", 32'(chg_flag), 0);
        repeat (11) step();
        chk("t5_pre_valid", 32'(code_valid), 0);
        step();
        chk("t5_relock", 32'(code_valid), 1);
        chk("t5_relock_sq", 32'(square_o), 32'h055);
        chk("t5_relock_sh", 32'(ship_o), 32'h02);

        // 6: input changes strictly between ticks
        next_tick();
        square_in = 12'hFFF; ship_in = 8'hAA;
        step(); step();
        square_in = 12'h055; ship_in = 8'h02;
        seen_chg = 0;
        repeat (3) next_tick();
        chk("t6_no_chg", 32'(seen_chg), 0);
        chk("t6_cand", 32'(dut.cand_q), 32'h02055);
        chk("t6_sq", 32'(square_o), 32'h055);
        chk("t6_unst", 32'(unstable), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
